// File: rtl/prl_rx_message_fifo_if.sv
// PRL RX message notification queue: buffers parsed RX messages for the policy engine
// behind a valid/ack handshake, with overflow tracking and flush on hard/protocol reset.
module prl_rx_message_fifo_if #(
    parameter int unsigned INFO_W = 23,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prl_rx_st_inform_pe_en,
    input  logic [1:0]        prl_rx_parser_message_type,
    input  logic [2:0]        prl_rx_parser_sop_type,
    input  logic [4:0]        prl_rx_parser_header_type,
    input  logic [INFO_W-1:0] prl_rx_parser_info,
    input  logic              prl_rx_flush,
    input  logic              pe2pl_rx_ack,
    input  logic              pe2pl_rx_overflow_clr,
    output logic              pl2pe_rx_valid,
    output logic [6:0]        pl2pe_rx_type,
    output logic [2:0]        pl2pe_rx_sop_type,
    output logic [INFO_W-1:0] pl2pe_rx_info,
    output logic [PTR_W:0]    pl2pe_rx_pending,
    output logic              pl2pe_rx_overflow,
    output logic [CNT_W-1:0]  pl2pe_rx_drop_cnt,
    output logic              prl_rx_fifo_full
);

    localparam int unsigned TYPE_W  = 7;
    localparam int unsigned SOP_W   = 3;
    localparam int unsigned ENTRY_W = TYPE_W + SOP_W + INFO_W;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     pending_q;
    logic               overflow_q;
    logic [CNT_W-1:0]   drop_cnt_q;

    logic               valid_c;
    logic               full_c;
    logic               do_pop_c;
    logic               do_push_c;
    logic               do_drop_c;
    logic [ENTRY_W-1:0] wr_entry_c;
    logic [ENTRY_W-1:0] head_c;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [PTR_W:0]     pending_d;
    logic               overflow_d;
    logic [CNT_W-1:0]   drop_cnt_d;

    assign valid_c = (pending_q != '0);
    assign full_c  = (pending_q == DEPTH_CNT);

    // Flush wins over everything; a full FIFO still accepts a push when the head is acked.
    always_comb begin
        do_pop_c   = 1'b0;
        do_push_c  = 1'b0;
        do_drop_c  = 1'b0;
        wr_entry_c = {prl_rx_parser_message_type, prl_rx_parser_header_type,
                      prl_rx_parser_sop_type, prl_rx_parser_info};
        if (!prl_rx_flush) begin
            do_pop_c  = pe2pl_rx_ack && valid_c;
            do_push_c = prl_rx_st_inform_pe_en && (!full_c || do_pop_c);
            do_drop_c = prl_rx_st_inform_pe_en && full_c && !do_pop_c;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pending_d = pending_q;
        if (prl_rx_flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            pending_d = '0;
        end else begin
            if (do_push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push_c && !do_pop_c) begin
                pending_d = pending_q + (PTR_W + 1)'(1);
            end else if (do_pop_c && !do_push_c) begin
                pending_d = pending_q - (PTR_W + 1)'(1);
            end
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (do_drop_c) begin
            overflow_d = 1'b1;
            if (pe2pl_rx_overflow_clr) begin
                drop_cnt_d = CNT_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end else if (pe2pl_rx_overflow_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_c) begin
            mem_q[wr_ptr_q] <= wr_entry_c;
        end
    end

    assign head_c = mem_q[rd_ptr_q];

    assign pl2pe_rx_valid    = valid_c;
    assign pl2pe_rx_type     = head_c[ENTRY_W-1 -: TYPE_W];
    assign pl2pe_rx_sop_type = head_c[INFO_W +: SOP_W];
    assign pl2pe_rx_info     = head_c[INFO_W-1:0];
    assign pl2pe_rx_pending  = pending_q;
    assign pl2pe_rx_overflow = overflow_q;
    assign pl2pe_rx_drop_cnt = drop_cnt_q;
    assign prl_rx_fifo_full  = full_c;

endmodule

// File: doc/prl_rx_message_fifo_if.md
Name: prl_rx_message_fifo_if

Overview:
Parametrised successor to the single-register PRL RX message interface. It queues parsed RX message notifications (type, SOP, packed info) in a DEPTH-entry FIFO. It presents the oldest entry to the policy engine with a valid/ack handshake, so back-to-back receptions are not lost while the PE is busy. It reports overflow, drop count and occupancy, and supports a flush on hard reset or protocol reset.

Parameters:
INFO_W, 23, width of packed message info field (bit layout owned by the parser)
DEPTH, 4, FIFO entries; power of two, 2..16
PTR_W, 2, log2(DEPTH); must match DEPTH
CNT_W, 8, width of saturating drop counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
prl_rx_st_inform_pe_en  input  1  push strobe from PRL RX state machine, one cycle per message
prl_rx_parser_message_type  input  2  message class
prl_rx_parser_sop_type  input  3  SOP* type
prl_rx_parser_header_type  input  5  header message type
prl_rx_parser_info  input  INFO_W  packed payload info
prl_rx_flush  input  1  discard all queued entries (hard reset / protocol reset)
pe2pl_rx_ack  input  1  PE consumes the head entry
pe2pl_rx_overflow_clr  input  1  clear overflow flag and drop counter
pl2pe_rx_valid  output  1  head entry valid
pl2pe_rx_type  output  7  {message_type, header_type} of head
pl2pe_rx_sop_type  output  3  SOP of head
pl2pe_rx_info  output  INFO_W  info of head
pl2pe_rx_pending  output  PTR_W+1  entries queued (0..DEPTH)
pl2pe_rx_overflow  output  1  sticky: a message was dropped
pl2pe_rx_drop_cnt  output  CNT_W  dropped messages, saturating
prl_rx_fifo_full  output  1  pending == DEPTH

Behaviour:
- Reset (rst_n low, asynchronous): pointers 0, pending 0, valid 0, type/sop/info 0, overflow 0, drop_cnt 0, full 0.
- Entry stored = {message_type, header_type, sop_type, info}, captured on the push cycle.
- Registered wr_ptr, rd_ptr and pending counter; pointers wrap modulo DEPTH.
- pl2pe_rx_valid = (pending != 0). Head outputs are driven from storage at rd_ptr and hold stable while valid and not acked.
- Latency: push into an empty FIFO at edge N gives valid and the head data visible after edge N (first cycle following the strobe).
- Pop: ack while valid advances rd_ptr at the next edge. Ack while not valid is ignored, with no underflow. Ack held high for consecutive cycles drains one entry per cycle.
- Push while not full: write at wr_ptr, advance wr_ptr.
- Push while full and no ack: message dropped and FIFO contents unchanged (oldest kept). Overflow is set to 1 and drop_cnt increments, saturating at 2^CNT_W-1.
- Push and ack in the same cycle while full: both take effect; pending stays DEPTH; no drop.
- Push and ack in the same cycle otherwise: pending unchanged, both pointers advance.
- Push into an empty FIFO with ack in the same cycle: ack ignored (valid was 0); pending becomes 1.
- Flush has priority over push and ack in the same cycle. It sets pointers and pending to 0, so valid is 0 on the next cycle, and the same-cycle push is discarded without counting as a drop. Overflow and drop_cnt are unaffected by flush.
- overflow_clr: overflow and drop_cnt go to 0 at the next edge. If a drop occurs in the same cycle, the drop wins: overflow = 1, drop_cnt = 1.
- prl_rx_fifo_full is registered-consistent with pending (combinational decode of the pending register); no look-ahead.
- Storage holds no reset requirement beyond the outputs above. Head outputs read 0 after reset until the first push.

Test Plan:
- Single push (type=2'b01, hdr=5'h02, sop=3'd0, info=23'h1234) with ack 3 cycles later -> valid rises the cycle after the push, type=7'h22, info=23'h001234; after ack, valid=0 and pending=0.
- 4 back-to-back pushes (info=1,2,3,4) with ack held high from cycle 2 -> PE sees info 1,2,3,4 in order, one per cycle; pending peaks at 4 or below; no overflow.
- 6 pushes with no ack (DEPTH=4) -> pending=4, full=1, overflow=1, drop_cnt=2, head info=1. Then 4 acks drain 1,2,3,4; the dropped 5 and 6 never appear.
- Full FIFO, push (info=9) together with ack -> head advances to 2, pending stays 4, drop_cnt unchanged; entry 9 later emerges last.
- 3 entries queued; flush asserted in the same cycle as a push -> next cycle valid=0 and pending=0; drop_cnt unchanged; a later push is delivered normally.
- overflow_clr in the same cycle as a drop -> overflow=1, drop_cnt=1. overflow_clr alone on a later cycle -> overflow=0, drop_cnt=0. Async reset mid-drain -> all outputs 0 immediately.
